seg_scan_decoder: RTL and testbench

Receiving end of the multiplexed six-digit seven-segment bus driven by the NCO counter/display top. It samples the scanned enable, segment and decimal-point lines and waits for each digit slot to settle. It then decodes the glyphs back to BCD and publishes a complete six-digit frame with a one-cycle valid strobe. It is used as an on-chip loopback checker and as a self-checking monitor in display testbenches.

---
 rtl/seg_scan_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receiver for a scanned six-digit seven-segment bus: debounces each digit slot,
// decodes glyphs back to BCD and publishes a whole frame with a one-cycle strobe.
module seg_scan_decoder #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_seg_enb,
    input  logic        i_seg_dp,
    input  logic [6:0]  i_seg,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_err,
    output logic        o_frame_vld,
    output logic        o_lost
);

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);
    localparam logic [13:0] IN_IDLE   = {6'h3F, 1'b0, 7'h00};

    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        logic [3:0] val;
        case (seg)
            7'b1111110: val = 4'd0;
            7'b0110000: val = 4'd1;
            7'b1101101: val = 4'd2;
            7'b1111001: val = 4'd3;
            7'b0110011: val = 4'd4;
            7'b1011011: val = 4'd5;
            7'b1011111: val = 4'd6;
            7'b1110000: val = 4'd7;
            7'b1111111: val = 4'd8;
            7'b1111011: val = 4'd9;
            7'b0000000: val = 4'hF;
            default:    val = 4'hE;
        endcase
        return val;
    endfunction

    // Counts low enables; a valid slot has exactly one, and idx reports which.
    function automatic logic [3:0] low_count(input logic [5:0] enb, output logic [2:0] idx);
        logic [3:0] cnt;
        cnt = 4'd0;
        idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (!enb[k]) begin
                cnt = cnt + 4'd1;
                idx = 3'(k);
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    logic [13:0] in_d, in_q;
    logic [3:0]  stb_d, stb_q;
    logic [19:0] to_d, to_q;
    logic [23:0] sh_dig_d, sh_dig_q;
    logic [5:0]  sh_dp_d, sh_dp_q, sh_err_d, sh_err_q, seen_d, seen_q;
    logic [23:0] o_digits_q;
    logic [5:0]  o_dp_q, o_err_q;
    logic        o_frame_vld_q, o_lost_q;
    logic        hold_s, slot_ok_s, capture_s, publish_s, timeout_s;
    logic [2:0]  slot_s;
    logic [3:0]  dec_s;

    assign in_d = {i_seg_enb, i_seg_dp, i_seg};

    // Stability tracking compares the incoming sample with the registered one,
    // so a new pattern restarts the count on the edge it is first registered.
    always_comb begin
        stb_d     = stb_q;
        slot_s    = 3'd0;
        hold_s    = (in_d == in_q);
        slot_ok_s = (low_count(in_q[13:8], slot_s) == 4'd1);
        dec_s     = decode_seg(in_q[6:0]);
        if (!hold_s) begin
            stb_d = 4'd0;
        end else if (stb_q < SETTLE_C) begin
            stb_d = stb_q + 4'd1;
        end else begin
            stb_d = stb_q;
        end
        capture_s = hold_s && (stb_q == SETTLE_M1) && slot_ok_s;
    end

    // Shadow update, frame completion and timeout decisions.
    always_comb begin
        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        sh_err_d  = sh_err_q;
        seen_d    = seen_q;
        to_d      = to_q;
        publish_s = 1'b0;
        timeout_s = 1'b0;
        if (capture_s) begin
            sh_dig_d[5'({slot_s, 2'b00}) +: 4] = dec_s;
            sh_dp_d[slot_s]  = in_q[7];
            sh_err_d[slot_s] = (dec_s == 4'hE);
            seen_d           = seen_q | (6'b000001 << slot_s);
            to_d             = 20'd0;
            if (seen_d == 6'b111111) begin
                publish_s = 1'b1;
                seen_d    = 6'b000000;
            end else begin
                publish_s = 1'b0;
            end
        end else if (to_q == TO_LAST) begin
            timeout_s = 1'b1;
            seen_d    = 6'b000000;
            to_d      = 20'd0;
        end else begin
            to_d = to_q + 20'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q          <= IN_IDLE;
            stb_q         <= 4'd0;
            to_q          <= 20'd0;
            sh_dig_q      <= 24'hFFFFFF;
            sh_dp_q       <= 6'd0;
            sh_err_q      <= 6'd0;
            seen_q        <= 6'd0;
            o_digits_q    <= 24'hFFFFFF;
            o_dp_q        <= 6'd0;
            o_err_q       <= 6'd0;
            o_frame_vld_q <= 1'b0;
            o_lost_q      <= 1'b0;
        end else begin
            in_q     <= in_d;
            stb_q    <= stb_d;
            to_q     <= to_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            sh_err_q <= sh_err_d;
            seen_q   <= seen_d;
            if (publish_s) begin
                o_digits_q    <= sh_dig_d;
                o_dp_q        <= sh_dp_d;
                o_err_q       <= sh_err_d;
                o_frame_vld_q <= 1'b1;
                o_lost_q      <= 1'b0;
            end else begin
                o_frame_vld_q <= 1'b0;
                o_lost_q      <= o_lost_q | timeout_s;
            end
        end
    end

    assign o_digits    = o_digits_q;
    assign o_dp        = o_dp_q;
    assign o_err       = o_err_q;
    assign o_frame_vld = o_frame_vld_q;
    assign o_lost      = o_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues expected frames,
// a negedge monitor pops and compares them whenever o_frame_vld is seen.
module tb_seg_scan_decoder;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  enb = 6'h3F;
    logic        dp = 1'b0;
    logic [6:0]  seg = 7'h00;
    logic [23:0] o_digits;
    logic [5:0]  o_dp, o_err;
    logic        o_frame_vld, o_lost;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_seg_enb(enb), .i_seg_dp(dp), .i_seg(seg),
        .o_digits(o_digits), .o_dp(o_dp), .o_err(o_err),
        .o_frame_vld(o_frame_vld), .o_lost(o_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        logic [5:0]  p;
        logic [5:0]  e;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t pend_e;
    bit   pend = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] gly [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [5:0] en(input int slot);
        logic [5:0] v;
        v = 6'h3F;
        v[slot] = 1'b0;
        return v;
    endfunction

    task automatic expect_frame(input logic [23:0] d, input logic [5:0] p, input logic [5:0] e);
        pend_e.d = d;
        pend_e.p = p;
        pend_e.e = e;
        pend = 1'b1;
    endtask

    // Holds one bus pattern for n clock edges; a pending frame is queued with its due cycle.
    task automatic drive(input logic [5:0] ev, input logic dv, input logic [6:0] sv, input int n);
        @(negedge clk);
        enb = ev;
        dp  = dv;
        seg = sv;
        if (pend) begin
            pend_e.c = cyc + 1 + SETTLE;
            q.push_back(pend_e);
            pend = 1'b0;
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic gap(input int n);
        drive(6'h3F, 1'b0, 7'h00, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, 32'(o_digits), 32'hFFFFFF);
        chk({tag, "_dp"}, 32'(o_dp), 32'h0);
        chk({tag, "_err"}, 32'(o_err), 32'h0);
        chk({tag, "_vld"}, 32'(o_frame_vld), 32'h0);
        chk({tag, "_lost"}, 32'(o_lost), 32'h0);
    endtask

    // Monitor: every strobe must match the oldest queued frame, on its due cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_frame_vld === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%0h required=none", o_digits);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_digits", 32'(o_digits), 32'(e.d));
                chk("frame_dp", 32'(o_dp), 32'(e.p));
                chk("frame_err", 32'(o_err), 32'(e.e));
                chk("frame_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Clean scan 1..6, dp on slot 2.
        for (int k = 0; k < 6; k++) begin
            if (k == 5) expect_frame(24'h654321, 6'b000100, 6'b000000);
            drive(en(k), k == 2, gly[k + 1], 4);
        end

        // Partial scan, async reset mid-scan, then only two slots: no publish.
        for (int k = 0; k < 4; k++) drive(en(k), 1'b0, gly[8], 4);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk) rst_n = 1'b1;
        drive(en(4), 1'b0, gly[8], 4);
        drive(en(5), 1'b0, gly[8], 4);
        gap(4);
        chk("no_publish_after_reset", 32'(o_digits), 32'hFFFFFF);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Glitch rejection: 1-cycle slot-3 glyph and a double enable are ignored.
        for (int k = 0; k < 4; k++) drive(en(k), 1'b0, gly[k], 4);
        drive(en(3), 1'b0, gly[8], 1);
        drive(en(4), 1'b0, gly[4], 4);
        drive(6'b110011, 1'b1, gly[8], 4);
        expect_frame(24'h543210, 6'b000000, 6'b000000);
        drive(en(5), 1'b0, gly[5], 4);

        // Illegal and blank glyphs.
        drive(en(0), 1'b0, gly[8], 4);
        drive(en(1), 1'b0, 7'b1000000, 4);
        drive(en(2), 1'b0, gly[8], 4);
        drive(en(3), 1'b0, gly[8], 4);
        drive(en(4), 1'b0, 7'b0000000, 4);
        expect_frame(24'h8F88E8, 6'b000000, 6'b000010);
        drive(en(5), 1'b0, gly[8], 4);

        // Overwrite with gaps: slot 2 seen twice, latest (9) wins.
        drive(en(0), 1'b0, gly[0], 4); gap(2);
        drive(en(1), 1'b0, gly[1], 4); gap(2);
        drive(en(2), 1'b0, gly[2], 4); gap(2);
        drive(en(2), 1'b0, gly[9], 4); gap(2);
        drive(en(3), 1'b0, gly[3], 4); gap(2);
        drive(en(4), 1'b0, gly[4], 4); gap(2);
        expect_frame(24'h543910, 6'b000000, 6'b000000);
        drive(en(5), 1'b0, gly[5], 4); gap(2);

        // Timeout after a partial frame; seen must be cleared.
        for (int k = 0; k < 3; k++) drive(en(k), 1'b0, gly[7], 4);
        gap(TIMEOUT - 20);
        chk("lost_before_timeout", 32'(o_lost), 32'h0);
        repeat (30) @(negedge clk);
        chk("lost_after_timeout", 32'(o_lost), 32'h1);
        chk("digits_kept_on_timeout", 32'(o_digits), 32'h543910);
        drive(en(3), 1'b0, gly[1], 4);
        drive(en(4), 1'b0, gly[2], 4);
        drive(en(5), 1'b0, gly[3], 4);
        chk("lost_held", 32'(o_lost), 32'h1);
        drive(en(0), 1'b0, gly[4], 4);
        drive(en(1), 1'b0, gly[5], 4);
        expect_frame(24'h321654, 6'b000000, 6'b000000);
        drive(en(2), 1'b0, gly[6], 4);
        gap(3);
        chk("lost_cleared", 32'(o_lost), 32'h0);

        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
